// File: rtl/icache_refill_unit_if.sv
// Fetch-side bus bundle for the instruction-cache refill unit: PC request,
// instruction return, cache lookup/write port and byte-wide memory read port.
interface icache_refill_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_res;
  logic        cache_we;
  logic [31:0] cache_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_data;

  // master: the refill unit itself
  modport master (
    input  req_valid, req_addr, cache_hit, cache_res,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, inst_valid, inst, inst_addr,
           cache_addr, cache_we, cache_data, mem_req_valid, mem_req_addr
  );

  // slave: fetch stage, cache array and memory controller around it
  modport slave (
    output req_valid, req_addr, cache_hit, cache_res,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, inst_valid, inst, inst_addr,
           cache_addr, cache_we, cache_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_refill_unit.sv
// Instruction-cache fetch client: 1-cycle hits, byte-serial little-endian refill
// from memory on a miss, write-back into the cache and delivery of the word.
module icache_refill_unit #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush,
  icache_refill_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_t      state;
  logic [31:0] miss_addr;
  logic [31:0] word;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        squash;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;

  logic [31:0] req_aligned;
  logic [2:0]  in_flight;
  logic        accept;
  logic        issue_ok;
  logic        mem_fire;
  logic        resp_fire;

  assign req_aligned = {bus.req_addr[31:2], 2'b00};
  assign in_flight   = issue_cnt - recv_cnt;
  assign accept      = (state == IDLE) && rdy_in && !flush && bus.req_valid;
  assign issue_ok    = (state == FETCH) && (issue_cnt < 3'd4) && (in_flight < MAX_OUT);
  assign mem_fire    = issue_ok && rdy_in && bus.mem_req_ready;
  assign resp_fire   = (state == FETCH) && rdy_in && bus.mem_resp_valid && (recv_cnt < 3'd4);

  // req_ready already folds in flush and freeze so a handshake always means acceptance
  assign bus.req_ready     = (state == IDLE) && rdy_in && !flush;
  assign bus.cache_addr    = (state == IDLE) ? req_aligned : miss_addr;
  assign bus.cache_we      = (state == WRITE) && rdy_in;
  assign bus.cache_data    = word;
  assign bus.mem_req_valid = issue_ok && rdy_in;
  assign bus.mem_req_addr  = miss_addr + 32'(issue_cnt);
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.inst_addr     = inst_addr_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      miss_addr    <= '0;
      word         <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      squash       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
    end else if (rdy_in) begin
      inst_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.cache_hit) begin
              inst_valid_q <= 1'b1;
              inst_q       <= bus.cache_res;
              inst_addr_q  <= req_aligned;
            end else begin
              miss_addr <= req_aligned;
              issue_cnt <= '0;
              recv_cnt  <= '0;
              squash    <= 1'b0;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (mem_fire) issue_cnt <= issue_cnt + 3'd1;
          // a redirect only suppresses delivery; the refill runs to completion
          if (flush) squash <= 1'b1;
          if (resp_fire) begin
            word[{recv_cnt[1:0], 3'b000} +: 8] <= bus.mem_resp_data;
            recv_cnt <= recv_cnt + 3'd1;
            if (recv_cnt == 3'd3) state <= WRITE;
          end
        end
        WRITE: begin
          if (!squash && !flush) begin
            inst_valid_q <= 1'b1;
            inst_q       <= word;
            inst_addr_q  <= miss_addr;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a byte response must always correspond to an outstanding request
  resp_has_request: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && bus.mem_resp_valid) |-> (state == FETCH && recv_cnt < issue_cnt));

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed + randomized bench for icache_refill_unit with a cache array model,
// an in-order byte memory model and word-level expected results.
module tb_icache_refill_unit;
  localparam int unsigned MO = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;
  logic flush  = 1'b0;

  icache_refill_unit_if bif();

  icache_refill_unit #(.MAX_OUTSTANDING(MO)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .flush (flush),
    .bus   (bif)
  );

  always #5 clk_in = ~clk_in;

  // direct-mapped cache array: 64 lines, index addr[7:2], tag addr[31:8]
  logic        cval [64];
  logic [23:0] ctag [64];
  logic [31:0] cdat [64];
  assign bif.cache_hit = cval[bif.cache_addr[7:2]] && (ctag[bif.cache_addr[7:2]] == bif.cache_addr[31:8]);
  assign bif.cache_res = cdat[bif.cache_addr[7:2]];

  int nassert = 0;
  int nfail   = 0;

  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned ready_mode = 0;
  logic [31:0] rq_addr[$];
  int unsigned rq_due[$];

  int n_inst, n_we, n_issued, n_memv;
  int unsigned we_cyc, inst_cyc;
  logic [31:0] we_data, we_addr, obs_inst, obs_addr, exp_base;
  bit accepted;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] t;
    case (a)
      32'h204: return 8'h93;
      32'h205: return 8'h00;
      32'h206: return 8'h10;
      32'h207: return 8'h00;
      default: begin
        t = (a * 32'd37) ^ (a >> 8) ^ 32'hA5;
        return t[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return 32'(mem_byte(a)) + 32'(mem_byte(a + 1)) * 32'd256 +
           32'(mem_byte(a + 2)) * 32'd65536 + 32'(mem_byte(a + 3)) * 32'd16777216;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory side driven at negedge, everything sampled 2 time units before posedge
  task automatic step();
    logic [5:0] ix;
    @(negedge clk_in);
    case (ready_mode)
      0:       bif.mem_req_ready = 1'b1;
      1:       bif.mem_req_ready = cyc[0];
      default: bif.mem_req_ready = 1'($urandom_range(0, 1));
    endcase
    if (rq_addr.size() != 0 && rq_due[0] <= cyc) begin
      bif.mem_resp_valid = 1'b1;
      bif.mem_resp_data  = mem_byte(rq_addr[0]);
    end else begin
      bif.mem_resp_valid = 1'b0;
      bif.mem_resp_data  = 8'($urandom);
    end
    #3;
    if (rst_in) begin
      if (!rdy_in) begin
        chk("freeze_mem_req_valid", 32'(bif.mem_req_valid), 32'd0);
        chk("freeze_cache_we", 32'(bif.cache_we), 32'd0);
      end
      if (bif.mem_req_valid) n_memv++;
      if (rdy_in && bif.req_valid && bif.req_ready && !flush) accepted = 1'b1;
      if (rdy_in && bif.mem_resp_valid) begin
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end
      if (rdy_in && bif.mem_req_valid && bif.mem_req_ready) begin
        chk("mem_req_addr", bif.mem_req_addr, exp_base + 32'(n_issued));
        rq_addr.push_back(bif.mem_req_addr);
        rq_due.push_back(cyc + lat);
        n_issued++;
        chk("outstanding_within_max", 32'(rq_addr.size() <= int'(MO)), 32'd1);
      end
      if (bif.cache_we) begin
        n_we++;
        we_data = bif.cache_data;
        we_addr = bif.cache_addr;
        we_cyc  = cyc;
        ix = bif.cache_addr[7:2];
        cval[ix] = 1'b1;
        ctag[ix] = bif.cache_addr[31:8];
        cdat[ix] = bif.cache_data;
      end
      if (rdy_in && bif.inst_valid) begin
        n_inst++;
        obs_inst = bif.inst;
        obs_addr = bif.inst_addr;
        inst_cyc = cyc;
      end
    end
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input bit do_flush, input int flush_after,
                          input bit do_freeze, input int freeze_after);
    logic [31:0] a, w;
    bit hit;
    a   = {addr[31:2], 2'b00};
    hit = cval[a[7:2]] && (ctag[a[7:2]] == a[31:8]);
    w   = hit ? cdat[a[7:2]] : ref_word(a);
    n_inst = 0; n_we = 0; n_issued = 0; n_memv = 0; accepted = 1'b0; exp_base = a;
    bif.req_addr  = {a[31:2], 2'($urandom_range(0, 3))};
    bif.req_valid = 1'b1;
    for (int k = 0; k < 20 && !accepted; k++) step();
    bif.req_valid = 1'b0;
    bif.req_addr  = $urandom;
    chk("req_accepted", 32'(accepted), 32'd1);
    if (hit) begin
      step();
      chk("hit_inst_valid", 32'(n_inst), 32'd1);
      chk("hit_inst", obs_inst, w);
      chk("hit_inst_addr", obs_addr, a);
      chk("hit_no_mem_req", 32'(n_memv), 32'd0);
    end else begin
      if (do_flush) begin
        repeat (flush_after) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      if (do_freeze) begin
        repeat (freeze_after) step();
        rdy_in = 1'b0;
        repeat (5) step();
        rdy_in = 1'b1;
      end
      for (int k = 0; k < 100 && n_we == 0; k++) step();
      step();
      step();
      chk("miss_cache_we_count", 32'(n_we), 32'd1);
      chk("miss_cache_data", we_data, w);
      chk("miss_cache_addr", we_addr, a);
      chk("miss_bytes_requested", 32'(n_issued), 32'd4);
      chk("miss_responses_drained", 32'(rq_addr.size()), 32'd0);
      if (do_flush) begin
        chk("flushed_no_inst", 32'(n_inst), 32'd0);
      end else begin
        chk("miss_inst_valid", 32'(n_inst), 32'd1);
        chk("miss_inst", obs_inst, w);
        chk("miss_inst_addr", obs_addr, a);
        chk("miss_inst_after_write", inst_cyc, we_cyc + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      cval[i] = 1'b0; ctag[i] = '0; cdat[i] = '0;
    end
    bif.req_valid = 1'b0; bif.req_addr = '0;
    bif.mem_req_ready = 1'b0; bif.mem_resp_valid = 1'b0; bif.mem_resp_data = '0;
    rdy_in = 1'b1;

    // reset state
    repeat (2) step();
    chk("rst_inst_valid", 32'(bif.inst_valid), 32'd0);
    chk("rst_cache_we", 32'(bif.cache_we), 32'd0);
    chk("rst_mem_req_valid", 32'(bif.mem_req_valid), 32'd0);
    chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_inst", bif.inst, 32'd0);
    chk("rst_inst_addr", bif.inst_addr, 32'd0);
    rst_in = 1'b1;
    step();

    // 1: hit on preloaded line
    cval[0] = 1'b1; ctag[0] = 24'h000001; cdat[0] = 32'h00000013;
    do_fetch(32'h100, 0, 0, 0, 0);

    // 2: miss, byte assembly, then re-request hits
    ready_mode = 0; lat = 1;
    do_fetch(32'h204, 0, 0, 0, 0);
    chk("t2_word_literal", obs_inst, 32'h00100093);
    do_fetch(32'h204, 0, 0, 0, 0);

    // 3: back-pressure and late responses
    cval[1] = 1'b0;
    ready_mode = 1; lat = 3;
    do_fetch(32'h204, 0, 0, 0, 0);
    chk("t3_word_literal", obs_inst, 32'h00100093);

    // 4: flush mid-refill, then flush in IDLE with a pending request
    ready_mode = 0; lat = 2;
    do_fetch(32'h300, 1, 2, 0, 0);
    do_fetch(32'h300, 0, 0, 0, 0);
    n_inst = 0; n_memv = 0;
    bif.req_addr = 32'h400; bif.req_valid = 1'b1; flush = 1'b1;
    repeat (3) step();
    flush = 1'b0; bif.req_valid = 1'b0;
    repeat (3) step();
    chk("idle_flush_no_inst", 32'(n_inst), 32'd0);
    chk("idle_flush_no_mem_req", 32'(n_memv), 32'd0);

    // 5: freeze mid-refill
    ready_mode = 2; lat = 2;
    do_fetch(32'h500, 0, 0, 1, 2);

    // 6: asynchronous reset mid-refill
    ready_mode = 0; lat = 3;
    n_issued = 0; exp_base = 32'h600; accepted = 1'b0;
    bif.req_addr = 32'h600; bif.req_valid = 1'b1;
    for (int k = 0; k < 20 && !accepted; k++) step();
    bif.req_valid = 1'b0;
    repeat (3) step();
    #2 rst_in = 1'b0;
    #1;
    chk("arst_inst_valid", 32'(bif.inst_valid), 32'd0);
    chk("arst_cache_we", 32'(bif.cache_we), 32'd0);
    chk("arst_mem_req_valid", 32'(bif.mem_req_valid), 32'd0);
    chk("arst_req_ready", 32'(bif.req_ready), 32'd1);
    chk("arst_inst", bif.inst, 32'd0);
    chk("arst_inst_addr", bif.inst_addr, 32'd0);
    rq_addr.delete(); rq_due.delete();
    bif.mem_resp_valid = 1'b0;
    repeat (2) step();
    rst_in = 1'b1;
    step();
    do_fetch(32'h600, 0, 0, 0, 0);

    // randomized fetch stream over colliding lines
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      int unsigned pick;
      lat        = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 2);
      ra   = 32'h1000 + (32'($urandom_range(0, 1)) << 8) + (32'($urandom_range(0, 7)) << 2);
      pick = $urandom_range(0, 7);
      if (pick == 0)      do_fetch(ra, 1, int'($urandom_range(0, 3)), 0, 0);
      else if (pick == 1) do_fetch(ra, 0, 0, 1, int'($urandom_range(0, 2)));
      else                do_fetch(ra, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
